// File: rtl/qupls_decode_mul_stage.sv
// Multiply-class decode stage: classifies each lane as mulu/muls/mulw, holds the
// bundle in a valid/ready output register and tracks multiplier issue-queue credits.

package qupls_decode_mul_pkg;
  localparam int INSTR_W = 32;
  typedef logic [INSTR_W-1:0] instruction_t;

  // opcode lives in [6:0], R3 function code in [31:25]
  localparam logic [6:0] OP_R3B  = 7'h02;
  localparam logic [6:0] OP_R3W  = 7'h03;
  localparam logic [6:0] OP_R3T  = 7'h04;
  localparam logic [6:0] OP_R3O  = 7'h05;
  localparam logic [6:0] OP_MULI = 7'h06;
  localparam logic [6:0] OP_MULUI = 7'h0E;

  localparam logic [6:0] FN_MUL   = 7'h0C;
  localparam logic [6:0] FN_MULW  = 7'h0D;
  localparam logic [6:0] FN_MULU  = 7'h0E;
  localparam logic [6:0] FN_MULUW = 7'h0F;

  // Returns {mulu, muls, mulw} for one instruction.
  function automatic logic [2:0] mul_class(input logic [6:0] op, input logic [6:0] fn);
    logic r3;
    logic mulu;
    logic muls;
    logic mulw;
    r3   = (op == OP_R3B) || (op == OP_R3W) || (op == OP_R3T) || (op == OP_R3O);
    mulu = (op == OP_MULUI) || (r3 && ((fn == FN_MULU) || (fn == FN_MULUW)));
    muls = (op == OP_MULI)  || (r3 && ((fn == FN_MUL)  || (fn == FN_MULW)));
    mulw = r3 && ((fn == FN_MULUW) || (fn == FN_MULW));
    return {mulu, muls, mulw};
  endfunction
endpackage

module qupls_decode_mul_stage #(
  parameter int NLANE      = 4,
  parameter int MUL_QDEPTH = 8,
  localparam int IW        = qupls_decode_mul_pkg::INSTR_W,
  localparam int CW        = $clog2(MUL_QDEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NLANE-1:0]      in_lane_v,
  input  logic [NLANE*IW-1:0]   in_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NLANE-1:0]      out_lane_v,
  output logic [NLANE*IW-1:0]   out_instr,
  output logic [NLANE-1:0]      out_mulu,
  output logic [NLANE-1:0]      out_muls,
  output logic [NLANE-1:0]      out_mulw,
  input  logic                  credit_ret,
  output logic [CW-1:0]         credits,
  output logic                  credit_err
);

  function automatic int popcnt(input logic [NLANE-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NLANE; i++) n += int'(v[i]);
    return n;
  endfunction

  logic [NLANE-1:0]    cls_mulu, cls_muls, cls_mulw;
  logic [2:0]          cls;
  int                  nmul_in, nmul_held, credit_sum;
  logic                accept;

  logic                out_valid_d, out_valid_q;
  logic [NLANE-1:0]    out_lane_v_d, out_lane_v_q;
  logic [NLANE*IW-1:0] out_instr_d, out_instr_q;
  logic [NLANE-1:0]    out_mulu_d, out_mulu_q;
  logic [NLANE-1:0]    out_muls_d, out_muls_q;
  logic [NLANE-1:0]    out_mulw_d, out_mulw_q;
  logic [CW-1:0]       credits_d, credits_q;
  logic                credit_err_d, credit_err_q;

  // Lane classification, masked by lane valid so idle lanes never cost credits.
  always_comb begin
    cls_mulu = '0;
    cls_muls = '0;
    cls_mulw = '0;
    cls      = '0;
    for (int i = 0; i < NLANE; i++) begin
      cls = qupls_decode_mul_pkg::mul_class(in_instr[i*IW +: 7], in_instr[i*IW+25 +: 7]);
      cls_mulu[i] = in_lane_v[i] & cls[2];
      cls_muls[i] = in_lane_v[i] & cls[1];
      cls_mulw[i] = in_lane_v[i] & cls[0];
    end
  end

  assign nmul_in   = popcnt(cls_mulu | cls_muls);
  assign nmul_held = popcnt(out_mulu_q | out_muls_q);
  assign in_ready  = !flush && (!out_valid_q || out_ready) && (nmul_in <= int'(credits_q));
  assign accept    = in_valid && in_ready;

  always_comb begin
    // NOTE: next-state logic is purely combinational with blocking assignments and
    // a default for every signal; only the always_ff below uses non-blocking updates.
    out_valid_d  = out_valid_q;
    out_lane_v_d = out_lane_v_q;
    out_instr_d  = out_instr_q;
    out_mulu_d   = out_mulu_q;
    out_muls_d   = out_muls_q;
    out_mulw_d   = out_mulw_q;
    credit_err_d = credit_err_q;

    if (accept) begin
      out_valid_d  = 1'b1;
      out_lane_v_d = in_lane_v;
      out_instr_d  = in_instr;
      out_mulu_d   = cls_mulu;
      out_muls_d   = cls_muls;
      out_mulw_d   = cls_mulw;
    end else if (flush || out_ready) begin
      out_valid_d = 1'b0;
    end

    // A held bundle killed by flush before being consumed hands its credits back.
    credit_sum = int'(credits_q) - (accept ? nmul_in : 0) + (credit_ret ? 1 : 0)
               + ((flush && out_valid_q && !out_ready) ? nmul_held : 0);
    if (credit_sum > MUL_QDEPTH) begin
      credit_sum   = MUL_QDEPTH;
      credit_err_d = 1'b1;
    end
    credits_d = CW'(credit_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the whole output register (data included) is reset so downstream
      // never observes X lanes or class bits after reset.
      out_valid_q  <= 1'b0;
      out_lane_v_q <= '0;
      out_instr_q  <= '0;
      out_mulu_q   <= '0;
      out_muls_q   <= '0;
      out_mulw_q   <= '0;
      credits_q    <= CW'(MUL_QDEPTH);
      credit_err_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_lane_v_q <= out_lane_v_d;
      out_instr_q  <= out_instr_d;
      out_mulu_q   <= out_mulu_d;
      out_muls_q   <= out_muls_d;
      out_mulw_q   <= out_mulw_d;
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_lane_v = out_lane_v_q;
  assign out_instr  = out_instr_q;
  assign out_mulu   = out_mulu_q;
  assign out_muls   = out_muls_q;
  assign out_mulw   = out_mulw_q;
  assign credits    = credits_q;
  assign credit_err = credit_err_q;

endmodule

// File: tb/tb_qupls_decode_mul_stage.sv
// Self-checking bench for qupls_decode_mul_stage: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level reference model.

module tb_qupls_decode_mul_stage;
  import qupls_decode_mul_pkg::*;

  localparam int NLANE = 4;
  localparam int QD    = 8;
  localparam int CW    = $clog2(QD + 1);

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, out_valid, out_ready, credit_ret, credit_err;
  logic [NLANE-1:0]    in_lane_v, out_lane_v, out_mulu, out_muls, out_mulw;
  logic [NLANE*32-1:0] in_instr, out_instr;
  logic [CW-1:0]       credits;

  always #5 clk = ~clk;

  qupls_decode_mul_stage #(.NLANE(NLANE), .MUL_QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_lane_v(in_lane_v), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane_v(out_lane_v),
    .out_instr(out_instr), .out_mulu(out_mulu), .out_muls(out_muls), .out_mulw(out_mulw),
    .credit_ret(credit_ret), .credits(credits), .credit_err(credit_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: the bundle currently held, the credit pool and the error flag.
  bit           m_init = 0;
  bit           m_valid;
  logic [3:0]   m_lane, m_mulu, m_muls, m_mulw;
  logic [127:0] m_instr;
  int           m_credits;
  bit           m_err;
  logic         last_in_ready;

  function automatic bit is_mulu(input logic [31:0] ins);
    return ins[6:0] == OP_MULUI ||
           (ins[6:0] inside {OP_R3B, OP_R3W, OP_R3T, OP_R3O} &&
            ins[31:25] inside {FN_MULU, FN_MULUW});
  endfunction
  function automatic bit is_muls(input logic [31:0] ins);
    return ins[6:0] == OP_MULI ||
           (ins[6:0] inside {OP_R3B, OP_R3W, OP_R3T, OP_R3O} &&
            ins[31:25] inside {FN_MUL, FN_MULW});
  endfunction
  function automatic bit is_mulw(input logic [31:0] ins);
    return ins[6:0] inside {OP_R3B, OP_R3W, OP_R3T, OP_R3O} &&
           ins[31:25] inside {FN_MULUW, FN_MULW};
  endfunction

  function automatic int bundle_muls(input logic [3:0] lv, input logic [127:0] b);
    int n = 0;
    for (int i = 0; i < NLANE; i++)
      if (lv[i] && (is_mulu(b[i*32 +: 32]) || is_muls(b[i*32 +: 32]))) n++;
    return n;
  endfunction

  function automatic bit model_ready();
    return !flush && (!m_valid || out_ready) && (bundle_muls(in_lane_v, in_instr) <= m_credits);
  endfunction

  task automatic compare();
    if (m_init) begin
      check("in_ready", in_ready, model_ready());
      check("out_valid", out_valid, m_valid);
      check("credits", credits, m_credits);
      check("credit_err", credit_err, m_err);
      if (m_valid) begin
        check("out_lane_v", out_lane_v, m_lane);
        check("out_instr", out_instr, m_instr);
        check("out_mulu", out_mulu, m_mulu);
        check("out_muls", out_muls, m_muls);
        check("out_mulw", out_mulw, m_mulw);
      end
    end
  endtask

  task automatic model_update();
    bit acc;
    int nc, held;
    if (rst) begin
      m_valid = 0; m_lane = 0; m_instr = 0; m_mulu = 0; m_muls = 0; m_mulw = 0;
      m_credits = QD; m_err = 0; m_init = 1;
      return;
    end
    if (!m_init) return;
    acc  = in_valid && model_ready();
    held = 0;
    for (int i = 0; i < NLANE; i++) held += (m_mulu[i] || m_muls[i]) ? 1 : 0;
    nc = m_credits + (credit_ret ? 1 : 0)
       - (acc ? bundle_muls(in_lane_v, in_instr) : 0)
       + ((flush && m_valid && !out_ready) ? held : 0);
    if (nc > QD) begin
      nc = QD;
      m_err = 1;
    end
    m_credits = nc;
    if (acc) begin
      m_valid = 1;
      m_lane  = in_lane_v;
      m_instr = in_instr;
      for (int i = 0; i < NLANE; i++) begin
        m_mulu[i] = in_lane_v[i] && is_mulu(in_instr[i*32 +: 32]);
        m_muls[i] = in_lane_v[i] && is_muls(in_instr[i*32 +: 32]);
        m_mulw[i] = in_lane_v[i] && is_mulw(in_instr[i*32 +: 32]);
      end
    end else if (flush || out_ready) begin
      m_valid = 0;
    end
  endtask

  // One clock: drive inputs, compare mid-cycle, then advance the model at the edge.
  task automatic step(input logic v, input logic [3:0] lv, input logic [127:0] b,
                      input logic ordy, input logic cret, input logic fl, input logic r);
    in_valid = v; in_lane_v = lv; in_instr = b;
    out_ready = ordy; credit_ret = cret; flush = fl; rst = r;
    @(negedge clk);
    #1;
    last_in_ready = in_ready;
    compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [6:0] fn);
    logic [17:0] mid;
    mid = 18'($urandom);
    return {fn, mid, op};
  endfunction

  function automatic logic [127:0] pk(input logic [31:0] i0, input logic [31:0] i1,
                                      input logic [31:0] i2, input logic [31:0] i3);
    return {i3, i2, i1, i0};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [8];
    logic [6:0] fns [6];
    ops = '{OP_R3B, OP_R3W, OP_R3T, OP_R3O, OP_MULI, OP_MULUI, 7'h10, 7'($urandom)};
    fns = '{FN_MUL, FN_MULW, FN_MULU, FN_MULUW, 7'h01, 7'($urandom)};
    return mk(ops[$urandom_range(0, 7)], fns[$urandom_range(0, 5)]);
  endfunction

  logic [31:0]  nop;
  logic [127:0] b1, b4, b3, b0, b1m, b2, bm, held;

  initial begin
    in_valid = 0; in_lane_v = 0; in_instr = 0; out_ready = 0;
    credit_ret = 0; flush = 0; rst = 1;
    nop = mk(7'h10, 7'h00);

    // Reset state
    step(0, 4'h0, '0, 1, 0, 0, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_credits", credits, QD);
    check("rst_credit_err", credit_err, 0);
    check("rst_out_mulu", out_mulu, 0);
    check("rst_out_instr", out_instr, 0);

    // Two multiplies decoded and registered, credits 8 -> 6
    b1 = pk(mk(OP_MULUI, 7'h00), nop, mk(OP_R3W, FN_MULUW), nop);
    step(1, 4'hF, b1, 1, 0, 0, 0);
    check("t1_out_valid", out_valid, 1);
    check("t1_out_mulu", out_mulu, 4'b0101);
    check("t1_out_muls", out_muls, 4'b0000);
    check("t1_out_mulw", out_mulw, 4'b0100);
    check("t1_credits", credits, 6);

    // Four multiplies -> credits 2, then a 3-multiply bundle must stall
    b4 = pk(mk(OP_MULI, 7'h00), mk(OP_R3B, FN_MUL), mk(OP_R3T, FN_MULU), mk(OP_R3O, FN_MULW));
    step(1, 4'hF, b4, 1, 0, 0, 0);
    check("t2_b4_muls", out_muls, 4'b1011);
    check("t2_credits2", credits, 2);
    step(0, 4'h0, '0, 1, 0, 0, 0);
    b3 = pk(mk(OP_MULUI, 7'h00), mk(OP_MULI, 7'h00), mk(OP_R3B, FN_MULUW), nop);
    step(1, 4'hF, b3, 1, 0, 0, 0);
    check("t2_stall_ready", last_in_ready, 0);
    check("t2_stall_valid", out_valid, 0);
    check("t2_stall_credits", credits, 2);
    step(1, 4'hF, b3, 1, 1, 0, 0);
    check("t2_ret_ready", last_in_ready, 0);
    check("t2_ret_credits", credits, 3);
    step(1, 4'hF, b3, 1, 0, 0, 0);
    check("t2_acc_ready", last_in_ready, 1);
    check("t2_acc_credits", credits, 0);
    check("t2_acc_mulu", out_mulu, 4'b0101);
    check("t2_acc_mulw", out_mulw, 4'b0100);

    // Output hold for 5 cycles, then consume and load in the same cycle
    b0 = pk(nop, nop, mk(7'h11, 7'h03), nop);
    held = out_instr;
    for (int i = 0; i < 5; i++) begin
      step(1, 4'hF, b0, 0, 0, 0, 0);
      check("t3_hold_ready", last_in_ready, 0);
      check("t3_hold_valid", out_valid, 1);
      check("t3_hold_instr", out_instr, b3);
      check("t3_hold_mulu", out_mulu, 4'b0101);
    end
    step(1, 4'hF, b0, 1, 0, 0, 0);
    check("t3_rel_ready", last_in_ready, 1);
    check("t3_rel_instr", out_instr, b0);
    check("t3_rel_valid", out_valid, 1);

    // Accept and return in the same cycle; then overflow
    for (int i = 0; i < 4; i++) step(0, 4'h0, '0, 1, 1, 0, 0);
    check("t4_credits4", credits, 4);
    b1m = pk(mk(OP_MULI, 7'h00), nop, nop, nop);
    step(1, 4'hF, b1m, 1, 1, 0, 0);
    check("t4_both_credits", credits, 4);
    for (int i = 0; i < 4; i++) step(0, 4'h0, '0, 1, 1, 0, 0);
    check("t4_full_credits", credits, 8);
    check("t4_no_err_yet", credit_err, 0);
    step(0, 4'h0, '0, 1, 1, 0, 0);
    check("t4_ovf_credits", credits, 8);
    check("t4_ovf_err", credit_err, 1);

    // Flush refund of a held 2-multiply bundle, then flush with consume (no refund)
    step(0, 4'h0, '0, 1, 0, 0, 1);
    check("t5_err_cleared", credit_err, 0);
    step(1, 4'hF, b3, 1, 0, 0, 0);
    b2 = pk(mk(OP_MULI, 7'h00), nop, mk(OP_R3W, FN_MULW), nop);
    step(1, 4'hF, b2, 1, 0, 0, 0);
    check("t5_credits3", credits, 3);
    step(0, 4'h0, '0, 0, 0, 1, 0);
    check("t5_flush_valid", out_valid, 0);
    check("t5_flush_refund", credits, 5);
    step(1, 4'hF, b2, 1, 0, 0, 0);
    step(1, 4'hF, b2, 1, 0, 1, 0);
    check("t5_flush_ready", last_in_ready, 0);
    check("t5_noref_credits", credits, 3);
    check("t5_noref_valid", out_valid, 0);

    // Masked lane multiply costs nothing; reset in the middle of a stall
    bm = pk(nop, mk(OP_MULI, 7'h00), nop, nop);
    step(1, 4'b1101, bm, 1, 0, 0, 0);
    check("t6_mask_muls", out_muls, 4'b0000);
    check("t6_mask_lane", out_lane_v, 4'b1101);
    check("t6_mask_credits", credits, 3);
    step(1, 4'hF, b4, 0, 0, 0, 0);
    step(1, 4'hF, b4, 0, 0, 0, 0);
    step(1, 4'hF, b4, 0, 0, 0, 1);
    check("t6_rst_credits", credits, 8);
    check("t6_rst_valid", out_valid, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 9) < 7, 4'($urandom),
           pk(rand_instr(), rand_instr(), rand_instr(), rand_instr()),
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
           $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
